vec_add_sched: RTL and testbench

//  Round-robin scheduler that shares one vec_add engine between NUM_REQ requesters (e.g. MPC party shares).

---
 rtl/vec_add_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/vec_add_sched.sv | 148 ++++++++++++++
 tb/tb_vec_add_sched.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vec_add_pkg.sv
// ============================================================================
// Module  : vec_add_pkg
// Brief   : Shared FSM encodings and sizing helper for the vec_add scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package vec_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational cyclic-priority pick: first request at or after ptr.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = `CLOG2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_valid
);

  int               w_cand;
  logic [SEL_W-1:0] w_cand_idx;

  always_comb begin
    o_gnt      = '0;
    o_idx      = '0;
    o_valid    = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_cand = int'(i_ptr) + off;
      if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
      w_cand_idx = SEL_W'(w_cand);
      if (!o_valid && i_req[w_cand_idx]) begin
        o_valid           = 1'b1;
        o_gnt[w_cand_idx] = 1'b1;
        o_idx             = w_cand_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vec_add_sched.sv
// ============================================================================
// Module  : vec_add_sched
// Brief   : Round-robin scheduler sharing one vec_add engine among requesters.
//           Optional watchdog enabled by defining VEC_ADD_SCHED_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module vec_add_sched
  import vec_add_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int SEL_W          = `CLOG2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_busy,
  output logic               o_eng_start,
  input  logic               i_eng_done,
  output logic [NUM_REQ-1:0] o_ack,
  output logic               o_err
);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("vec_add_sched: NUM_REQ must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("vec_add_sched: TIMEOUT_CYCLES must be >= 1");
  end

  sched_state_t       r_state;
  sched_state_t       w_state_nxt;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   r_sel;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_start;
  logic               r_busy;
  logic               w_timeout;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [SEL_W-1:0]   w_arb_idx;
  logic               w_arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_arb (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_arb_valid) w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (i_eng_done || w_timeout) w_state_nxt = ST_ACK;
      ST_ACK:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // All outputs are registered; start/ack therefore appear one cycle after
  // the state that causes them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr   <= '0;
      r_sel   <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_start <= (r_state == ST_START);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_ack   <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_gnt <= w_arb_gnt;
            r_sel <= w_arb_idx;
          end
        end
        ST_WAIT: begin
          if (w_state_nxt == ST_ACK) r_ack <= r_gnt;
        end
        ST_ACK: begin
          r_gnt <= '0;
          r_ptr <= (r_sel == SEL_W'(NUM_REQ - 1)) ? '0 : r_sel + SEL_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef VEC_ADD_SCHED_TIMEOUT_EN
  localparam int c_wd_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_wd_w-1:0] r_wd;
  logic              r_err;

  // Fires on the TIMEOUT_CYCLES-th consecutive WAIT cycle without done.
  assign w_timeout = (r_state == ST_WAIT) && !i_eng_done &&
                     (r_wd == c_wd_w'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if ((r_state == ST_WAIT) && (w_state_nxt == ST_WAIT)) r_wd <= r_wd + c_wd_w'(1);
      else                                                   r_wd <= '0;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  assign o_gnt       = r_gnt;
  assign o_sel       = r_sel;
  assign o_busy      = r_busy;
  assign o_eng_start = r_start;
  assign o_ack       = r_ack;

endmodule

`default_nettype wire

// File: tb/tb_vec_add_sched.sv
// ============================================================================
// Module  : tb_vec_add_sched
// Brief   : Directed self-checking bench for vec_add_sched (NUM_REQ=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vec_add_sched;

  localparam int c_num_req = 4;
`ifdef VEC_ADD_SCHED_TIMEOUT_EN
  localparam int c_timeout = 16;
`else
  localparam int c_timeout = 1024;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] o_gnt;
  logic [1:0] o_sel;
  logic       o_busy;
  logic       o_eng_start;
  logic [3:0] o_ack;
  logic       o_err;

  int n_err    = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  vec_add_sched #(
    .NUM_REQ        (c_num_req),
    .TIMEOUT_CYCLES (c_timeout)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .o_gnt       (o_gnt),
    .o_sel       (o_sel),
    .o_busy      (o_busy),
    .o_eng_start (o_eng_start),
    .i_eng_done  (done),
    .o_ack       (o_ack),
    .o_err       (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One full job for requester idx, starting from an IDLE cycle with its request up.
  task automatic serve(input int idx, input int wait_cycles, input logic [3:0] req_after);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    step();
    chk("gnt", o_gnt, oh);
    chk("sel", o_sel, idx);
    chk("busy", o_busy, 1);
    chk("start_early", o_eng_start, 0);
    step();
    chk("start", o_eng_start, 1);
    chk("ack_early", o_ack, 0);
    for (int i = 0; i < wait_cycles; i++) begin
      step();
      chk("wait_start", o_eng_start, 0);
      chk("wait_ack", o_ack, 0);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    chk("ack", o_ack, oh);
    chk("gnt_in_ack", o_gnt, oh);
    req = req_after;
    step();
    chk("ack_pulse", o_ack, 0);
    chk("idle_busy", o_busy, 0);
    chk("idle_gnt", o_gnt, 0);
    chk("idle_sel_hold", o_sel, idx);
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    step();
    step();
    chk("rst_gnt", o_gnt, 0);
    chk("rst_sel", o_sel, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_start", o_eng_start, 0);
    chk("rst_ack", o_ack, 0);
    chk("rst_err", o_err, 0);
    rst = 1'b0;

    // Single requester 1 from pointer 0.
    req = 4'b0010;
    serve(1, 2, 4'b0000);

    // Spurious done while IDLE.
    done = 1'b1;
    step();
    done = 1'b0;
    chk("spur_idle_ack", o_ack, 0);
    chk("spur_idle_busy", o_busy, 0);
    chk("spur_idle_gnt", o_gnt, 0);

    // Spurious done in START must not skip WAIT.
    req = 4'b0100;
    step();
    chk("spur_start_gnt", o_gnt, 4'b0100);
    chk("spur_start_sel", o_sel, 2);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("spur_start_ack", o_ack, 0);
    chk("spur_start_pulse", o_eng_start, 1);
    step();
    chk("spur_still_wait_ack", o_ack, 0);
    chk("spur_still_wait_busy", o_busy, 1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("spur_real_ack", o_ack, 4'b0100);
    req = 4'b0000;
    step();
    chk("spur_idle_after", o_busy, 0);

    // Pointer now 3: serve req3, then req0 wins over req3 after the wrap.
    req = 4'b1000;
    serve(3, 0, 4'b1001);
    serve(0, 0, 4'b1000);
    serve(3, 0, 4'b0000);

    // All requesting from pointer 0: order 0,1,2,3,0.
    req = 4'b1111;
    serve(0, 0, 4'b1111);
    serve(1, 1, 4'b1111);
    serve(2, 0, 4'b1111);
    serve(3, 0, 4'b1111);
    serve(0, 0, 4'b1111);

    // Reset in WAIT while requester 1 is being served.
    step();
    chk("pre_rst_gnt", o_gnt, 4'b0010);
    step();
    step();
    chk("pre_rst_busy", o_busy, 1);
    rst = 1'b1;
    #1;
    chk("async_busy", o_busy, 0);
    chk("async_gnt", o_gnt, 0);
    chk("async_sel", o_sel, 0);
    chk("async_ack", o_ack, 0);
    chk("async_start", o_eng_start, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_gnt", o_gnt, 4'b0001);
    chk("post_rst_sel", o_sel, 0);
    step();
    chk("post_rst_start", o_eng_start, 1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("post_rst_ack", o_ack, 4'b0001);
    req = 4'b0000;
    step();
    chk("post_rst_idle", o_busy, 0);

`ifdef VEC_ADD_SCHED_TIMEOUT_EN
    // Pointer 1; engine never answers.
    req = 4'b0010;
    step();
    chk("to_gnt", o_gnt, 4'b0010);
    step();
    chk("to_start", o_eng_start, 1);
    for (int i = 0; i < c_timeout - 1; i++) begin
      step();
      chk("to_wait_err", o_err, 0);
      chk("to_wait_ack", o_ack, 0);
    end
    step();
    chk("to_err", o_err, 1);
    chk("to_ack", o_ack, 4'b0010);
    req = 4'b0000;
    step();
    chk("to_err_sticky", o_err, 1);
    chk("to_idle", o_busy, 0);
    step();
    chk("to_err_sticky2", o_err, 1);
`else
    chk("err_tied", o_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire
